// File: rtl/uart_pkg.sv
// Shared UART-side definitions: transmit-arbiter state encoding and default byte width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Default byte width shared by the tx and rx sides.
  localparam int DATA_W_DEF = 8;

  // Transmit arbiter states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SEND    = 2'd2,
    ST_RELEASE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after i_ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the result.
// Ports: i_req (requests), i_ptr (last served index),
//        o_onehot / o_idx (winner), o_any (some request set).
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    int          w_cand;
    logic        w_found;
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = 0;
    // Scan from ptr+1 around to ptr itself, so ptr has the lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % N_REQ;
      if (!w_found && i_req[w_cand[IW-1:0]]) begin
        w_found                      = 1'b1;
        o_idx                        = w_cand[IW-1:0];
        o_onehot[w_cand[IW-1:0]]     = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources, round-robin, capped at MAX_BURST bytes per grant.
// Latency: req in IDLE at cycle n -> grant n+1 -> tx_start/ack n+2; tx_done at m -> next tx_start m+2.
// Backpressure: holds in LOAD while i_tx_busy is high; a watchdog aborts a frame whose tx_done never comes.
// Ports: clk/reset (async, active-high); i_req/i_req_data from sources, o_ack/o_grant back to them;
//        o_tx_start/o_tx_data to the transmitter, i_tx_busy/i_tx_done from it; o_timeout_err on abort.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_ack,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_tx_start,
  output logic [DATA_W-1:0]       o_tx_data,
  input  logic                    i_tx_busy,
  input  logic                    i_tx_done,
  output logic                    o_timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(TIMEOUT_CYC);

  tx_state_t          r_state;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_ptr;
  logic [BW-1:0]      r_burst;
  logic [WW-1:0]      r_wdog;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_ack;
  logic               r_tx_start;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_timeout;

  tx_state_t          w_state_nxt;
  logic [IW-1:0]      w_owner_nxt;
  logic [IW-1:0]      w_ptr_nxt;
  logic [BW-1:0]      w_burst_nxt;
  logic [WW-1:0]      w_wdog_nxt;
  logic [N_REQ-1:0]   w_grant_nxt;
  logic [N_REQ-1:0]   w_ack_nxt;
  logic               w_tx_start_nxt;
  logic [DATA_W-1:0]  w_tx_data_nxt;
  logic               w_timeout_nxt;

  logic [N_REQ-1:0]   w_pick_oh;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_ptr      <= IW'(N_REQ - 1);   // requester 0 wins first after reset
      r_burst    <= '0;
      r_wdog     <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_burst    <= w_burst_nxt;
      r_wdog     <= w_wdog_nxt;
      r_grant    <= w_grant_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_burst_nxt    = r_burst;
    w_wdog_nxt     = r_wdog;
    w_grant_nxt    = r_grant;
    w_ack_nxt      = '0;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_timeout_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_owner_nxt = w_pick_idx;
          w_grant_nxt = w_pick_oh;
          w_burst_nxt = '0;
          w_state_nxt = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (!i_req[r_owner]) begin
          w_state_nxt = ST_RELEASE;
        end else if (!i_tx_busy) begin
          w_tx_start_nxt     = 1'b1;
          w_tx_data_nxt      = i_req_data[r_owner*DATA_W +: DATA_W];
          w_ack_nxt[r_owner] = 1'b1;
          w_burst_nxt        = r_burst + BW'(1);
          w_wdog_nxt         = '0;
          w_state_nxt        = ST_SEND;
        end
      end

      ST_SEND: begin
        // tx_done is checked first so it wins over a same-cycle watchdog expiry.
        if (i_tx_done) begin
          if (r_burst == BW'(MAX_BURST) || !i_req[r_owner]) begin
            w_state_nxt = ST_RELEASE;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else if (r_wdog == WW'(TIMEOUT_CYC - 1)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_RELEASE;
        end else begin
          w_wdog_nxt = r_wdog + WW'(1);
        end
      end

      ST_RELEASE: begin
        w_ptr_nxt   = r_owner;
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign o_ack         = r_ack;
  assign o_grant       = r_grant;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_timeout_err = r_timeout;

endmodule
